// File: rtl/dp_mem_responder.sv
//------------------------------------------------------------------------------
// Module   : dp_mem_responder
// Brief    : Arbitrates datapath instruction/data requests onto a single RAM
//            port, with a wait timeout, sticky error flag and halt handling.
//            Optional one-entry fetch buffer enabled by macro DP_RESP_IBUF_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dp_mem_responder #(
    parameter int RAM_TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    input  logic        halt,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    localparam int          CW          = $clog2(RAM_TIMEOUT + 2);
    localparam logic [1:0]  c_RS_ACCESS = 2'b10;
    localparam logic [1:0]  c_RS_ERROR  = 2'b11;
    localparam logic [31:0] c_BAD_DATA  = 32'hBAD1_BAD1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DREQ   = 3'd1,
        S_IREQ   = 3'd2,
        S_RESP   = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t          r_state;
    logic            r_ihit;
    logic            r_dhit;
    logic            r_ramren;
    logic            r_ramwen;
    logic [31:0]     r_ramaddr;
    logic [31:0]     r_ramstore;
    logic [31:0]     r_imemload;
    logic [31:0]     r_dmemload;
    logic            r_err;
    logic            r_wr;
    logic            r_halt_pend;
    logic [CW-1:0]   r_cnt;

    logic            w_buf_hit;
    logic [31:0]     w_buf_data;
    logic            w_dreq_any;
    logic            w_waiting;
    logic            w_access;
    logic            w_fault;

    assign w_dreq_any = dmemREN | dmemWEN;
    assign w_waiting  = (r_state == S_DREQ) || (r_state == S_IREQ);
    assign w_access   = w_waiting && (ramstate == c_RS_ACCESS);
    assign w_fault    = w_waiting && !w_access &&
                        ((ramstate == c_RS_ERROR) || (r_cnt == CW'(RAM_TIMEOUT)));

`ifdef DP_RESP_IBUF_EN
    logic        r_bvalid;
    logic [31:0] r_btag;
    logic [31:0] r_bdata;

    // A buffered fetch only short-circuits when IDLE would otherwise start an IREQ.
    assign w_buf_hit  = (r_state == S_IDLE) && !halt && imemREN && !w_dreq_any &&
                        r_bvalid && !r_err && (imemaddr == r_btag);
    assign w_buf_data = r_bdata;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_bvalid <= 1'b0;
            r_btag   <= 32'd0;
            r_bdata  <= 32'd0;
        end else if (w_fault || r_err) begin
            r_bvalid <= 1'b0;
        end else if ((r_state == S_DREQ) && r_wr && (r_ramaddr == r_btag)) begin
            r_bvalid <= 1'b0;
        end else if ((r_state == S_IREQ) && w_access) begin
            r_bvalid <= 1'b1;
            r_btag   <= r_ramaddr;
            r_bdata  <= ramload;
        end
    end
`else
    assign w_buf_hit  = 1'b0;
    assign w_buf_data = 32'd0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_ihit      <= 1'b0;
            r_dhit      <= 1'b0;
            r_ramren    <= 1'b0;
            r_ramwen    <= 1'b0;
            r_ramaddr   <= 32'd0;
            r_ramstore  <= 32'd0;
            r_imemload  <= 32'd0;
            r_dmemload  <= 32'd0;
            r_err       <= 1'b0;
            r_wr        <= 1'b0;
            r_halt_pend <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ihit <= 1'b0;
                    r_dhit <= 1'b0;
                    if (halt) begin
                        r_state <= S_HALTED;
                    end else if (w_dreq_any) begin
                        r_state     <= S_DREQ;
                        r_ramaddr   <= dmemaddr;
                        r_ramstore  <= dmemstore;
                        r_wr        <= dmemWEN;
                        r_ramwen    <= dmemWEN;
                        r_ramren    <= ~dmemWEN;
                        r_cnt       <= '0;
                        r_halt_pend <= 1'b0;
                    end else if (imemREN) begin
                        if (w_buf_hit) begin
                            r_imemload <= w_buf_data;
                        end else begin
                            r_state     <= S_IREQ;
                            r_ramaddr   <= imemaddr;
                            r_ramstore  <= dmemstore;
                            r_wr        <= 1'b0;
                            r_ramwen    <= 1'b0;
                            r_ramren    <= 1'b1;
                            r_cnt       <= '0;
                            r_halt_pend <= 1'b0;
                        end
                    end
                end

                S_DREQ, S_IREQ: begin
                    if (halt) begin
                        r_halt_pend <= 1'b1;
                    end
                    if (w_access || w_fault) begin
                        r_state  <= S_RESP;
                        r_ramren <= 1'b0;
                        r_ramwen <= 1'b0;
                        if (w_fault) begin
                            r_err <= 1'b1;
                        end
                        if (r_state == S_DREQ) begin
                            r_dhit     <= 1'b1;
                            r_dmemload <= w_access ? ramload : c_BAD_DATA;
                        end else begin
                            r_ihit     <= 1'b1;
                            r_imemload <= w_access ? ramload : c_BAD_DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_RESP: begin
                    r_ihit   <= 1'b0;
                    r_dhit   <= 1'b0;
                    r_ramren <= 1'b0;
                    r_ramwen <= 1'b0;
                    r_state  <= (halt || r_halt_pend) ? S_HALTED : S_IDLE;
                end

                S_HALTED: begin
                    r_ihit   <= 1'b0;
                    r_dhit   <= 1'b0;
                    r_ramren <= 1'b0;
                    r_ramwen <= 1'b0;
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_ihit   <= 1'b0;
                    r_dhit   <= 1'b0;
                    r_ramren <= 1'b0;
                    r_ramwen <= 1'b0;
                end
            endcase
        end
    end

    assign ihit     = r_ihit | w_buf_hit;
    assign imemload = w_buf_hit ? w_buf_data : r_imemload;
    assign dhit     = r_dhit;
    assign dmemload = r_dmemload;
    assign ramREN   = r_ramren;
    assign ramWEN   = r_ramwen;
    assign ramaddr  = r_ramaddr;
    assign ramstore = r_ramstore;
    assign err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dp_mem_responder.sv
//------------------------------------------------------------------------------
// Module   : tb_dp_mem_responder
// Brief    : Directed self-checking bench for dp_mem_responder (RAM_TIMEOUT=4).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dp_mem_responder;

    localparam logic [1:0] c_FREE = 2'b00;
    localparam logic [1:0] c_BUSY = 2'b01;
    localparam logic [1:0] c_ACC  = 2'b10;

    logic        CLK;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        dhit;
    logic [31:0] dmemload;
    logic        halt;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        err;

    int total;
    int bad;

    dp_mem_responder #(.RAM_TIMEOUT(4)) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .imemREN   (imemREN),
        .imemaddr  (imemaddr),
        .ihit      (ihit),
        .imemload  (imemload),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .dmemaddr  (dmemaddr),
        .dmemstore (dmemstore),
        .dhit      (dhit),
        .dmemload  (dmemload),
        .halt      (halt),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .ramload   (ramload),
        .ramstate  (ramstate),
        .err       (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        RST = 1'b1; imemREN = 1'b0; imemaddr = '0; dmemREN = 1'b0; dmemWEN = 1'b0;
        dmemaddr = '0; dmemstore = '0; halt = 1'b0; ramload = '0; ramstate = c_FREE;
        tick();
        tick();
        check_val("rst_ihit", ihit, 0);
        check_val("rst_dhit", dhit, 0);
        check_val("rst_ramren", ramREN, 0);
        check_val("rst_ramwen", ramWEN, 0);
        check_val("rst_err", err, 0);
        check_val("rst_ramaddr", ramaddr, 0);
        check_val("rst_imemload", imemload, 0);
        check_val("rst_dmemload", dmemload, 0);
        RST = 1'b0;

        // Minimum-latency instruction fetch
        imemREN = 1'b1; imemaddr = 32'h0; ramstate = c_BUSY;
        tick();
        check_val("f0_ramren", ramREN, 1);
        check_val("f0_ramwen", ramWEN, 0);
        check_val("f0_ramaddr", ramaddr, 32'h0);
        check_val("f0_ihit_early", ihit, 0);
        imemREN = 1'b0; ramstate = c_ACC; ramload = 32'h3C01_0001;
        tick();
        check_val("f0_ihit", ihit, 1);
        check_val("f0_imemload", imemload, 32'h3C01_0001);
        check_val("f0_ramren_off", ramREN, 0);
        check_val("f0_dhit", dhit, 0);
        ramstate = c_FREE; ramload = '0;
        tick();
        check_val("f0_ihit_1cyc", ihit, 0);
        check_val("f0_imemload_hold", imemload, 32'h3C01_0001);
        check_val("f0_ramren_once", ramREN, 0);

        // Simultaneous write + fetch: data wins
        dmemWEN = 1'b1; imemREN = 1'b1; dmemaddr = 32'h100; imemaddr = 32'h100;
        dmemstore = 32'hDEAD_BEEF; ramstate = c_BUSY;
        tick();
        check_val("wr_ramwen", ramWEN, 1);
        check_val("wr_ramren", ramREN, 0);
        check_val("wr_ramaddr", ramaddr, 32'h100);
        check_val("wr_ramstore", ramstore, 32'hDEAD_BEEF);
        ramstate = c_ACC;
        tick();
        check_val("wr_dhit", dhit, 1);
        check_val("wr_ihit", ihit, 0);
        check_val("wr_ramwen_off", ramWEN, 0);
        dmemWEN = 1'b0; ramstate = c_FREE;
        tick();
        check_val("wr_dhit_1cyc", dhit, 0);
        check_val("resp_no_reissue", ramREN, 0);
        tick();
        check_val("if_ramren", ramREN, 1);
        check_val("if_ramaddr", ramaddr, 32'h100);
        imemREN = 1'b0; ramstate = c_ACC; ramload = 32'h1111_2222;
        tick();
        check_val("if_ihit", ihit, 1);
        check_val("if_imemload", imemload, 32'h1111_2222);
        ramstate = c_FREE;
        tick();

        // Asynchronous reset in the middle of an access
        dmemREN = 1'b1; dmemaddr = 32'h200; ramstate = c_BUSY;
        tick();
        check_val("ab_ramren", ramREN, 1);
        check_val("ab_ramaddr", ramaddr, 32'h200);
        #2 RST = 1'b1;
        #1;
        check_val("ab_async_ramren", ramREN, 0);
        check_val("ab_async_ramaddr", ramaddr, 0);
        dmemREN = 1'b0; ramstate = c_ACC; ramload = 32'h5555_5555;
        tick();
        check_val("ab_no_dhit", dhit, 0);
        check_val("ab_dmemload", dmemload, 0);
        RST = 1'b0; ramstate = c_FREE;
        tick();
        check_val("ab_idle_dhit", dhit, 0);
        check_val("ab_idle_ramren", ramREN, 0);

        // RAM stuck BUSY: timeout after 4 counted wait cycles
        dmemREN = 1'b1; dmemaddr = 32'h300; ramstate = c_BUSY;
        tick();
        check_val("to_ramren", ramREN, 1);
        dmemREN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("to_wait_dhit", dhit, 0);
            check_val("to_wait_err", err, 0);
        end
        tick();
        check_val("to_dhit", dhit, 1);
        check_val("to_err", err, 1);
        check_val("to_dmemload", dmemload, 32'hBAD1_BAD1);
        check_val("to_ramren_off", ramREN, 0);
        tick();
        check_val("to_dhit_1cyc", dhit, 0);
        check_val("to_err_sticky", err, 1);
        dmemREN = 1'b1; dmemaddr = 32'h304;
        tick();
        dmemREN = 1'b0; ramstate = c_ACC; ramload = 32'h7777_7777;
        tick();
        check_val("to2_dhit", dhit, 1);
        check_val("to2_dmemload", dmemload, 32'h7777_7777);
        check_val("to2_err_sticky", err, 1);
        ramstate = c_FREE;
        tick();
        RST = 1'b1;
        tick();
        check_val("to_err_clr", err, 0);
        RST = 1'b0;

        // Halt during a data access
        dmemREN = 1'b1; dmemaddr = 32'h400; ramstate = c_BUSY;
        tick();
        check_val("h_ramren", ramREN, 1);
        halt = 1'b1; dmemREN = 1'b0;
        tick();
        check_val("h_wait_dhit", dhit, 0);
        ramstate = c_ACC; ramload = 32'hCAFE_F00D;
        tick();
        check_val("h_dhit", dhit, 1);
        check_val("h_dmemload", dmemload, 32'hCAFE_F00D);
        ramstate = c_FREE; imemREN = 1'b1; dmemREN = 1'b1; imemaddr = 32'h500; dmemaddr = 32'h504;
        tick();
        check_val("h_dhit_off", dhit, 0);
        tick();
        check_val("h_ramren_blk", ramREN, 0);
        check_val("h_ramwen_blk", ramWEN, 0);
        tick();
        check_val("h_ihit_blk", ihit, 0);
        check_val("h_ramren_blk2", ramREN, 0);
        RST = 1'b1; imemREN = 1'b0; dmemREN = 1'b0; halt = 1'b0;
        tick();
        RST = 1'b0;

        // First fetch of 0x40 (also proves return to IDLE after reset)
        imemREN = 1'b1; imemaddr = 32'h40; ramstate = c_BUSY;
        tick();
        check_val("b1_ramren", ramREN, 1);
        imemREN = 1'b0; ramstate = c_ACC; ramload = 32'h0A0A_0A0A;
        tick();
        check_val("b1_ihit", ihit, 1);
        check_val("b1_imemload", imemload, 32'h0A0A_0A0A);
        ramstate = c_FREE; ramload = '0;
        tick();

        // Second fetch of 0x40
        imemREN = 1'b1; imemaddr = 32'h40;
        #1;
`ifdef DP_RESP_IBUF_EN
        check_val("b2_ihit_same", ihit, 1);
        check_val("b2_imemload", imemload, 32'h0A0A_0A0A);
        check_val("b2_no_ramren", ramREN, 0);
        imemREN = 1'b0;
        tick();
        check_val("b2_no_ramren_nxt", ramREN, 0);
        check_val("b2_ihit_off", ihit, 0);
`else
        check_val("b2_ihit_same", ihit, 0);
        tick();
        check_val("b2_ramren", ramREN, 1);
        imemREN = 1'b0; ramstate = c_ACC; ramload = 32'h0A0A_0A0A;
        tick();
        check_val("b2_ihit", ihit, 1);
        check_val("b2_imemload", imemload, 32'h0A0A_0A0A);
        ramstate = c_FREE;
        tick();
`endif

        // Write to 0x40 then fetch 0x40 must hit RAM
        dmemWEN = 1'b1; dmemaddr = 32'h40; dmemstore = 32'h1234_5678; ramstate = c_BUSY;
        tick();
        check_val("b3_ramwen", ramWEN, 1);
        dmemWEN = 1'b0; ramstate = c_ACC;
        tick();
        check_val("b3_dhit", dhit, 1);
        ramstate = c_FREE;
        tick();
        imemREN = 1'b1; imemaddr = 32'h40;
        #1;
        check_val("b4_no_buf_hit", ihit, 0);
        tick();
        check_val("b4_ramren", ramREN, 1);
        imemREN = 1'b0; ramstate = c_ACC; ramload = 32'h0B0B_0B0B;
        tick();
        check_val("b4_ihit", ihit, 1);
        check_val("b4_imemload", imemload, 32'h0B0B_0B0B);
        ramstate = c_FREE;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
